// File: rtl/param_fifo.sv
// Single-clock FIFO with selectable FWFT read mode, programmable almost flags,
// occupancy output, synchronous clear and sticky overflow/underflow flags.
module param_fifo #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wa_s, ra_s;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == {CW{1'b0}});
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // Acceptance is gated by the registered status, so a full FIFO never writes
  // through and an empty FIFO never bypasses.
  assign wa_s = wr_en & ~full;
  assign ra_s = rd_en & ~empty;

  // Next-state for pointers, occupancy and sticky error flags; clr wins.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wa_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (ra_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wa_s, ra_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (wr_en & full);
      udf_d = udf_q | (rd_en & empty);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wa_s && !clr) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] dout_q;

      // Registered read port: loads the head word on each accepted read.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout_q <= {WIDTH{1'b0}};
        end else if (clr) begin
          dout_q <= {WIDTH{1'b0}};
        end else if (ra_s) begin
          dout_q <= mem[rd_ptr_q];
        end else begin
          dout_q <= dout_q;
        end
      end

      assign data_out = dout_q;
    end else begin : g_fwft
      assign data_out = mem[rd_ptr_q];
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: one standard-read instance and one FWFT instance.
module tb_param_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr, wr_en, rd_en;
  logic [15:0] data_in, data_out;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  count;

  logic        f_clr, f_wr, f_rd;
  logic [15:0] f_din, f_dout;
  logic        f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0]  f_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_fifo #(.WIDTH(16), .DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .reset_n(reset_n), .clr(clr), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  param_fifo #(.WIDTH(16), .DEPTH(16), .FWFT(1)) u_fw (
    .clk(clk), .reset_n(reset_n), .clr(f_clr), .data_in(f_din),
    .wr_en(f_wr), .rd_en(f_rd), .data_out(f_dout), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 16'h0000;
    f_clr = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_din = 16'h0000;
    #12;
    n_cmp++;
    if ({count, empty, full, almost_empty, almost_full, overflow, underflow} !== {5'd0, 6'b101000}) begin
      n_bad++;
      $display("FAIL reset_status got cnt=%0d e=%b f=%b ae=%b af=%b o=%b u=%b want 0 1 0 1 0 0 0",
               count, empty, full, almost_empty, almost_full, overflow, underflow);
    end
    n_cmp++;
    if (data_out !== 16'h0000) begin
      n_bad++; $display("FAIL reset_dout got %h want 0000", data_out);
    end
    n_cmp++;
    if ({f_count, f_empty, f_full} !== {5'd0, 2'b10}) begin
      n_bad++; $display("FAIL reset_fwft got cnt=%0d e=%b f=%b want 0 1 0", f_count, f_empty, f_full);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_in = 16'(i);
      step();
      n_cmp++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 14)) begin
        n_bad++; $display("FAIL fill_%0d got cnt=%0d af=%b want cnt=%0d af=%b", i, count, almost_full, i + 1, (i + 1 >= 14));
      end
    end
    n_cmp++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL fill_full got f=%b o=%b want 1 0", full, overflow);
    end
    data_in = 16'hDEAD;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_bad++; $display("FAIL fill_overflow got o=%b cnt=%0d want 1 16", overflow, count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      n_cmp++;
      if (data_out !== 16'(i) || count !== 5'(15 - i) || almost_empty !== (15 - i <= 2)) begin
        n_bad++; $display("FAIL drain_%0d got d=%h cnt=%0d ae=%b want d=%h cnt=%0d ae=%b",
                          i, data_out, count, almost_empty, 16'(i), 15 - i, (15 - i <= 2));
      end
    end
    n_cmp++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      n_bad++; $display("FAIL drain_empty got e=%b u=%b want 1 0", empty, underflow);
    end
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (underflow !== 1'b1 || data_out !== 16'h000F || count !== 5'd0) begin
      n_bad++; $display("FAIL drain_underflow got u=%b d=%h cnt=%0d want 1 000f 0", underflow, data_out, count);
    end
  endtask

  task automatic test_back_to_back();
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || underflow !== 1'b0 || overflow !== 1'b0 || data_out !== 16'h0000) begin
      n_bad++; $display("FAIL b2b_clr got cnt=%0d u=%b o=%b d=%h want 0 0 0 0000", count, underflow, overflow, data_out);
    end
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = 16'h0100 + 16'(i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0105 + 16'(i);
      step();
      n_cmp++;
      if (count !== 5'd5 || data_out !== 16'h0100 + 16'(i)) begin
        n_bad++; $display("FAIL b2b_%0d got cnt=%0d d=%h want 5 %h", i, count, data_out, 16'h0100 + 16'(i));
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (data_out !== 16'h0114 + 16'(i) || count !== 5'(4 - i)) begin
        n_bad++; $display("FAIL b2b_tail_%0d got d=%h cnt=%0d want %h %0d", i, data_out, count, 16'h0114 + 16'(i), 4 - i);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_in = 16'h0200 + 16'(i);
      step();
    end
    rd_en = 1'b1; data_in = 16'hBEEF;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 5'd15 || overflow !== 1'b1 || data_out !== 16'h0200) begin
      n_bad++; $display("FAIL bnd_full got cnt=%0d o=%b d=%h want 15 1 0200", count, overflow, data_out);
    end
    for (int i = 1; i < 16; i++) begin
      step();
      n_cmp++;
      if (data_out !== 16'h0200 + 16'(i)) begin
        n_bad++; $display("FAIL bnd_drain_%0d got %h want %h", i, data_out, 16'h0200 + 16'(i));
      end
    end
    rd_en = 1'b0;
    n_cmp++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_bad++; $display("FAIL bnd_nowrite got e=%b cnt=%0d want 1 0", empty, count);
    end
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h3333;
    step();
    wr_en = 1'b0;
    n_cmp++;
    if (count !== 5'd1 || underflow !== 1'b1 || data_out !== 16'h020F) begin
      n_bad++; $display("FAIL bnd_empty got cnt=%0d u=%b d=%h want 1 1 020f", count, underflow, data_out);
    end
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (data_out !== 16'h3333 || count !== 5'd0) begin
      n_bad++; $display("FAIL bnd_stored got d=%h cnt=%0d want 3333 0", data_out, count);
    end
  endtask

  task automatic test_fwft();
    f_wr = 1'b1; f_din = 16'hABCD;
    step();
    f_wr = 1'b0;
    n_cmp++;
    if (f_dout !== 16'hABCD || f_empty !== 1'b0 || f_count !== 5'd1) begin
      n_bad++; $display("FAIL fwft_show got d=%h e=%b cnt=%0d want abcd 0 1", f_dout, f_empty, f_count);
    end
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    n_cmp++;
    if (f_empty !== 1'b1 || f_count !== 5'd0) begin
      n_bad++; $display("FAIL fwft_pop got e=%b cnt=%0d want 1 0", f_empty, f_count);
    end
    f_wr = 1'b1; f_din = 16'h1111;
    step();
    f_din = 16'h2222;
    step();
    f_wr = 1'b0;
    n_cmp++;
    if (f_dout !== 16'h1111 || f_count !== 5'd2) begin
      n_bad++; $display("FAIL fwft_head got d=%h cnt=%0d want 1111 2", f_dout, f_count);
    end
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    n_cmp++;
    if (f_dout !== 16'h2222 || f_count !== 5'd1) begin
      n_bad++; $display("FAIL fwft_next got d=%h cnt=%0d want 2222 1", f_dout, f_count);
    end
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; data_in = 16'h0400 + 16'(i);
      step();
    end
    n_cmp++;
    if (count !== 5'd9 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL clr_pre got cnt=%0d o=%b want 9 1", count, overflow);
    end
    clr = 1'b1; data_in = 16'h5555;
    step();
    clr = 1'b0; wr_en = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1 || data_out !== 16'h0000) begin
      n_bad++; $display("FAIL clr_post got cnt=%0d o=%b u=%b e=%b d=%h want 0 0 0 1 0000",
                        count, overflow, underflow, empty, data_out);
    end
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; rd_en = (i > 0); data_in = 16'h0700 + 16'(i);
      f_wr = 1'b1; f_din = 16'h0700 + 16'(i);
      step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({count, empty, full, almost_empty, almost_full, overflow, underflow} !== {5'd0, 6'b101000} ||
        data_out !== 16'h0000 || f_count !== 5'd0 || f_empty !== 1'b1) begin
      n_bad++; $display("FAIL async_reset got cnt=%0d e=%b d=%h fcnt=%0d fe=%b want 0 1 0000 0 1",
                        count, empty, data_out, f_count, f_empty);
    end
    wr_en = 1'b0; f_wr = 1'b0; rd_en = 1'b1;
    reset_n = 1'b1;
    step();
    rd_en = 1'b0;
    n_cmp++;
    if (underflow !== 1'b1 || count !== 5'd0 || data_out !== 16'h0000) begin
      n_bad++; $display("FAIL post_reset_empty got u=%b cnt=%0d d=%h want 1 0 0000", underflow, count, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_boundaries();
    test_fwft();
    test_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
